alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered ALU with valid/ready handshakes on input and output.
//  Extends the base 8-bit opcode set with variable shifts, rotates, an iterative multiply and status flags.
//  Sits between the operand fetch stage and the writeback stage of the datapath.
//  Single-cycle ops complete in 1 clock; MUL runs as a multi-cycle shift-add state machine.
// PARAMETERS
//  WIDTH   8   operand/result width; power of two, >= 4
//  SHW     3   shift-amount width, must equal log2(WIDTH)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset (0 = reset)
//  op_valid   in   1      operand/opcode presented
//  op_ready   out  1      block accepts op this cycle (transfer = op_valid & op_ready)
//  opcode     in   4      operation select (table below)
//  data1      in   WIDTH  operand a
//  data2      in   WIDTH  operand b / shift amount
//  res_valid  out  1      hasil/flags hold a valid result
//  res_ready  in   1      consumer takes result (transfer = res_valid & res_ready)
//  hasil      out  WIDTH  result register
//  flags      out  4      {N,V,C,Z} registered with hasil
//  busy       out  1      MUL in progress
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; res_valid=0, hasil=0, flags=0, busy=0; op_ready=0 while reset is held.
//  Reset mid-MUL aborts the op and discards it.
//  Opcodes (a=data1, b=data2, all results truncated to WIDTH):
//   0000 PASS a | 0001 AND | 0010 OR | 0011 XOR | 0100 ADD | 0101 SUB a-b
//   0110 SHR a>>b | 0111 SHL a<<b (b>=WIDTH -> 0) | 1000 NOT a
//   1001 MUL low WIDTH bits of a*b (unsigned)
//   1010 ROR by b[SHW-1:0] | 1011 ROL by b[SHW-1:0]
//   1100-1111 illegal: hasil=0, flags=4'b0000, still returns res_valid
//  Flags:
//   Z = (hasil==0)
//   N = hasil[WIDTH-1]
//   C: ADD carry-out; SUB borrow (a<b); SHR/SHL last bit shifted out (0 if b==0 or b>WIDTH); MUL 1 if upper product half !=0; else 0
//   V: signed overflow for ADD/SUB only; else 0
//  FSM states:
//   IDLE: op_ready = ~res_valid | res_ready.
//     On accept of a non-MUL op: hasil/flags/res_valid=1 load next edge (latency 1).
//     On accept of MUL: latch a,b; clear acc; go to MUL; busy=1.
//   MUL: one shift-add step per cycle, WIDTH cycles (counter WIDTH-1..0); op_ready=0.
//     On count 0: result loads into hasil; res_valid=1; busy=0; -> IDLE.
//     Latency from accept = WIDTH+1 cycles.
//  Output register:
//   hasil/flags are stable while res_valid & ~res_ready.
//   res_valid clears on res_ready unless a new result loads the same edge.
//   Simultaneous drain and accept in IDLE gives full throughput of 1 op/cycle.
//   Inputs are ignored when op_valid=0 or op_ready=0; no X propagation to hasil.
// TESTING (WIDTH=8)
//  1. Reset:
//     reset=0 mid-stream -> res_valid=0, hasil=0, flags=0 immediately.
//     Release, then ADD 8'hFF+8'h01 -> hasil=8'h00, flags Z=1, C=1, V=0, N=0 one cycle after accept.
//  2. Signed arithmetic:
//     SUB 8'h80-8'h01 -> 8'h7F, V=1, C=0.
//     SUB 8'h03-8'h05 -> 8'hFE, C=1, N=1.
//  3. Shifts and rotates:
//     SHL 8'h81 by 1 -> 8'h02, C=1.
//     SHR 8'hF0 by 9 -> 8'h00, Z=1.
//     ROR 8'h01 by 3 -> 8'h20.
//     ROL 8'h80 by 1 -> 8'h01.
//  4. MUL:
//     8'h10*8'h11 -> hasil=8'h10, C=1, res_valid exactly 9 cycles after accept; busy=1 throughout.
//     op_ready=0 until completion.
//  5. Back-pressure:
//     res_ready=0 with result pending -> op_ready=0, hasil held.
//     Streaming AND/OR/XOR with res_ready=1 -> one result per cycle, in order.
//  6. Illegal opcode 4'hD -> hasil=0, flags=0, res_valid=1.
//     Reset asserted during MUL -> no result produced after release.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle between operand fetch, alu_pipe and writeback.
// The master side issues operations and consumes results; alu_pipe is the slave.
interface alu_pipe_if #(
   parameter int WIDTH = 8
);
   logic             op_valid;
   logic             op_ready;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] data1;
   logic [WIDTH-1:0] data2;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] hasil;
   logic [3:0]       flags;
   logic             busy;

   modport master (
      output op_valid, opcode, data1, data2, res_ready,
      input  op_ready, res_valid, hasil, flags, busy
   );

   modport slave (
      input  op_valid, opcode, data1, data2, res_ready,
      output op_ready, res_valid, hasil, flags, busy
   );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes; single-cycle logic/arith/shift ops
// and a WIDTH-cycle shift-add multiplier. flags = {N,V,C,Z}.
module alu_pipe #(
   parameter int WIDTH = 8,
   parameter int SHW   = 3
) (
   input  logic       clk,
   input  logic       reset,
   alu_pipe_if.slave  bus
);
   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t               state_q, state_d;
   logic                 res_valid_q, res_valid_d;
   logic [WIDTH-1:0]     hasil_q, hasil_d;
   logic [3:0]           flags_q, flags_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [SHW-1:0]       cnt_q, cnt_d;

   logic                 op_ready_int;
   logic                 accept;
   logic [2*WIDTH-1:0]   acc_step;
   logic [WIDTH:0]       sum_ext, diff_ext, shr_ext, shl_ext;
   logic [2*WIDTH-1:0]   ror_ext, rol_ext;
   logic [WIDTH-1:0]     alu_res;
   logic                 alu_c, alu_v, illegal;

   // Single-cycle datapath; extended vectors carry the carry/borrow/shifted-out bit
   always_comb begin
      sum_ext  = {1'b0, bus.data1} + {1'b0, bus.data2};
      diff_ext = {1'b0, bus.data1} - {1'b0, bus.data2};
      shr_ext  = {bus.data1, 1'b0} >> bus.data2;
      shl_ext  = {1'b0, bus.data1} << bus.data2;
      ror_ext  = {bus.data1, bus.data1} >> bus.data2[SHW-1:0];
      rol_ext  = {bus.data1, bus.data1} << bus.data2[SHW-1:0];
      alu_res  = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      illegal  = 1'b0;
      case (bus.opcode)
         4'h0: alu_res = bus.data1;
         4'h1: alu_res = bus.data1 & bus.data2;
         4'h2: alu_res = bus.data1 | bus.data2;
         4'h3: alu_res = bus.data1 ^ bus.data2;
         4'h4: begin
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (bus.data1[WIDTH-1] == bus.data2[WIDTH-1]) &&
                      (sum_ext[WIDTH-1] != bus.data1[WIDTH-1]);
         end
         4'h5: begin
            alu_res = diff_ext[WIDTH-1:0];
            alu_c   = diff_ext[WIDTH];
            alu_v   = (bus.data1[WIDTH-1] != bus.data2[WIDTH-1]) &&
                      (diff_ext[WIDTH-1] != bus.data1[WIDTH-1]);
         end
         4'h6: begin
            alu_res = shr_ext[WIDTH:1];
            alu_c   = shr_ext[0];
         end
         4'h7: begin
            alu_res = shl_ext[WIDTH-1:0];
            alu_c   = shl_ext[WIDTH];
         end
         4'h8: alu_res = ~bus.data1;
         4'h9: alu_res = '0;
         4'hA: alu_res = ror_ext[WIDTH-1:0];
         4'hB: alu_res = rol_ext[2*WIDTH-1:WIDTH];
         default: illegal = 1'b1;
      endcase
   end

   assign acc_step     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   assign op_ready_int = (state_q == S_IDLE) && (!res_valid_q || bus.res_ready);
   assign accept       = bus.op_valid && op_ready_int;

   // Control FSM and output register
   always_comb begin
      state_d     = state_q;
      res_valid_d = res_valid_q && !bus.res_ready;
      hasil_d     = hasil_q;
      flags_d     = flags_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (bus.opcode == 4'h9) begin
                  mcand_d  = {{WIDTH{1'b0}}, bus.data1};
                  mplier_d = bus.data2;
                  acc_d    = '0;
                  cnt_d    = SHW'(WIDTH - 1);
                  state_d  = S_MUL;
               end else begin
                  hasil_d     = alu_res;
                  flags_d     = illegal ? 4'b0000 :
                                {alu_res[WIDTH-1], alu_v, alu_c, alu_res == '0};
                  res_valid_d = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               hasil_d     = acc_step[WIDTH-1:0];
               flags_d     = {acc_step[WIDTH-1], 1'b0, |acc_step[2*WIDTH-1:WIDTH],
                              acc_step[WIDTH-1:0] == '0};
               res_valid_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         res_valid_q <= 1'b0;
         hasil_q     <= '0;
         flags_q     <= '0;
      end else begin
         state_q     <= state_d;
         res_valid_q <= res_valid_d;
         hasil_q     <= hasil_d;
         flags_q     <= flags_d;
      end
   end

   // Multiplier working registers are only meaningful in S_MUL, so they need no reset
   always_ff @(posedge clk) begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
   end

   assign bus.op_ready  = reset && op_ready_int;
   assign bus.res_valid = res_valid_q;
   assign bus.hasil     = hasil_q;
   assign bus.flags     = flags_q;
   assign bus.busy      = (state_q == S_MUL);
endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (WIDTH=8): handshakes, flags, MUL latency, reset.
module tb_alu_pipe;
   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   lat;
   logic seen_res;

   alu_pipe_if #(.WIDTH(8)) bus ();

   alu_pipe #(.WIDTH(8), .SHW(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one op at a negedge, let it be accepted on the next posedge,
   // and return at the following negedge with op_valid dropped.
   task automatic do_op(input string tag, input logic [3:0] op,
                        input logic [7:0] a, input logic [7:0] b);
      bus.op_valid = 1'b1;
      bus.opcode   = op;
      bus.data1    = a;
      bus.data2    = b;
      #1;
      chk({tag, "_op_ready"}, bus.op_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      bus.op_valid = 1'b0;
   endtask

   task automatic chk_res(input string tag, input logic [7:0] h, input logic [3:0] f);
      chk({tag, "_res_valid"}, bus.res_valid, 1'b1);
      chk({tag, "_hasil"}, bus.hasil, h);
      chk({tag, "_flags"}, bus.flags, f);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      reset         = 1'b0;
      bus.op_valid  = 1'b0;
      bus.opcode    = 4'h0;
      bus.data1     = 8'h00;
      bus.data2     = 8'h00;
      bus.res_ready = 1'b1;
      repeat (2) @(negedge clk);

      chk("rst_res_valid", bus.res_valid, 1'b0);
      chk("rst_hasil", bus.hasil, 8'h00);
      chk("rst_flags", bus.flags, 4'h0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_op_ready", bus.op_ready, 1'b0);
      reset = 1'b1;
      @(negedge clk);

      do_op("add_ff_01", 4'h4, 8'hFF, 8'h01);
      chk_res("add_ff_01", 8'h00, 4'b0011);

      // Asynchronous reset with a result pending, between clock edges
      do_op("pre_rst", 4'h0, 8'h5A, 8'h00);
      chk_res("pre_rst", 8'h5A, 4'b0000);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_res_valid", bus.res_valid, 1'b0);
      chk("async_rst_hasil", bus.hasil, 8'h00);
      chk("async_rst_flags", bus.flags, 4'h0);
      chk("async_rst_op_ready", bus.op_ready, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      do_op("sub_80_01", 4'h5, 8'h80, 8'h01);
      chk_res("sub_80_01", 8'h7F, 4'b0100);
      do_op("sub_03_05", 4'h5, 8'h03, 8'h05);
      chk_res("sub_03_05", 8'hFE, 4'b1010);
      do_op("shl_81_1", 4'h7, 8'h81, 8'h01);
      chk_res("shl_81_1", 8'h02, 4'b0010);
      do_op("shr_f0_9", 4'h6, 8'hF0, 8'h09);
      chk_res("shr_f0_9", 8'h00, 4'b0001);
      do_op("shr_f0_8", 4'h6, 8'hF0, 8'h08);
      chk_res("shr_f0_8", 8'h00, 4'b0011);
      do_op("ror_01_3", 4'hA, 8'h01, 8'h03);
      chk_res("ror_01_3", 8'h20, 4'b0000);
      do_op("rol_80_1", 4'hB, 8'h80, 8'h01);
      chk_res("rol_80_1", 8'h01, 4'b0000);
      do_op("not_0f", 4'h8, 8'h0F, 8'h00);
      chk_res("not_0f", 8'hF0, 4'b1000);
      do_op("illegal_d", 4'hD, 8'h12, 8'h34);
      chk_res("illegal_d", 8'h00, 4'b0000);

      // MUL: busy and op_ready=0 until the result lands
      bus.op_valid = 1'b1;
      bus.opcode   = 4'h9;
      bus.data1    = 8'h10;
      bus.data2    = 8'h11;
      #1;
      chk("mul_op_ready", bus.op_ready, 1'b1);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      bus.opcode = 4'h4;
      while (!bus.res_valid && lat < 20) begin
         chk("mul_busy", bus.busy, 1'b1);
         chk("mul_op_ready_low", bus.op_ready, 1'b0);
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      bus.op_valid = 1'b0;
      chk("mul_latency", lat, 9);
      chk_res("mul_10_11", 8'h10, 4'b0010);
      chk("mul_busy_done", bus.busy, 1'b0);
      @(negedge clk);

      // Back-pressure: result held while the consumer stalls
      bus.res_ready = 1'b0;
      do_op("bp_xor", 4'h3, 8'h5A, 8'h0F);
      chk_res("bp_xor", 8'h55, 4'b0000);
      bus.op_valid = 1'b1;
      bus.opcode   = 4'h4;
      bus.data1    = 8'h01;
      bus.data2    = 8'h01;
      repeat (2) @(negedge clk);
      chk("bp_op_ready", bus.op_ready, 1'b0);
      chk_res("bp_hold", 8'h55, 4'b0000);
      bus.res_ready = 1'b1;
      #1;
      chk("bp_release_op_ready", bus.op_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      bus.op_valid = 1'b0;
      chk_res("bp_drain_accept", 8'h02, 4'b0000);

      // Streaming: one result per cycle, in order
      bus.op_valid = 1'b1;
      bus.data1    = 8'hCC;
      bus.data2    = 8'hAA;
      bus.opcode   = 4'h1;
      @(posedge clk);
      @(negedge clk);
      chk_res("stream_and", 8'h88, 4'b1000);
      bus.opcode = 4'h2;
      @(posedge clk);
      @(negedge clk);
      chk_res("stream_or", 8'hEE, 4'b1000);
      bus.opcode = 4'h3;
      @(posedge clk);
      @(negedge clk);
      chk_res("stream_xor", 8'h66, 4'b0000);
      bus.op_valid = 1'b0;
      @(negedge clk);
      chk("stream_drained", bus.res_valid, 1'b0);

      // Reset during MUL discards the operation
      do_op("mul_abort", 4'h9, 8'h03, 8'h05);
      repeat (3) @(negedge clk);
      chk("mul_abort_busy", bus.busy, 1'b1);
      reset = 1'b0;
      #1;
      chk("mul_abort_busy_rst", bus.busy, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      seen_res = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.res_valid) seen_res = 1'b1;
      end
      chk("mul_abort_no_result", seen_res, 1'b0);
      chk("mul_abort_hasil", bus.hasil, 8'h00);
      chk("mul_abort_op_ready", bus.op_ready, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
